uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares one `UART_TX` transmitter between `NUM_REQ` byte-stream requesters with message-granular round-robin arbitration. Each requester presents bytes on a valid/ready interface with a `last` marker. The scheduler holds the grant until the message ends or a burst limit is reached, paces bytes against the transmitter's `busy`/`done` handshake, and inserts a programmable idle gap between messages. It sits between the protocol engines and the `UART_wrapper` TX port.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, byte width; matches the UART `DATA_WIDTH`
- `MAX_BURST`, 16, maximum bytes per grant before forced re-arbitration
- `GAP_BITS`, 8, width of `gap_cycles`
- `STALL_CYCLES`, 1024, SEND-state starvation limit before the grant is aborted

- `clk` input 1 single clock, rising edge
- `rst` input 1 reset, asynchronous, active-low
- `gap_cycles` input GAP_BITS idle clocks inserted after each grant ends
- `req_valid` input NUM_REQ per-requester byte valid
- `req_data` input NUM_REQ*DATA_WIDTH flattened bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_last` input NUM_REQ final byte of the message
- `req_ready` output NUM_REQ one-hot byte accept
- `uart_tx_data` output DATA_WIDTH to `TX_dataIn`
- `uart_tx_en` output 1 to `TX_en`; one-cycle pulse per byte
- `uart_tx_busy` input 1 from `TX_busy`
- `uart_tx_done` input 1 from `TX_done`; one-cycle pulse at end of frame
- `grant_active` output 1 a requester currently holds the transmitter
- `grant_id` output $clog2(NUM_REQ) index of the current or most recent grantee
- `abort_pulse` output 1 one-cycle pulse when a grant is revoked by stall timeout

## Operation
- States: IDLE, SEND, WAIT, GAP.
- IDLE: if any `req_valid`, the round-robin arbiter picks the first asserted index starting at `rr_ptr`. Register `grant_id`, set `grant_active`, clear the burst and stall counters, and go to SEND. Otherwise stay in IDLE.
- SEND:
  - If `req_valid[grant_id]` and `!uart_tx_busy`: combinationally assert `req_ready[grant_id]` and `uart_tx_en`, drive `uart_tx_data = req_data[grant_id]`, latch `req_last`, increment the burst count, and go to WAIT.
  - Otherwise the stall count increments. When it reaches `STALL_CYCLES-1`, pulse `abort_pulse` and end the grant.
- WAIT: hold until `uart_tx_done`. Then:
  - If the latched last is set or the burst count equals `MAX_BURST`, end the grant.
  - Otherwise clear the stall count and return to SEND.
- End of grant:
  - `grant_active` goes to 0.
  - `rr_ptr` becomes `grant_id+1`, wrapping from `NUM_REQ-1` to 0.
  - Go to GAP if `gap_cycles!=0`, else to IDLE.
- GAP: count `gap_cycles` clocks, then go to IDLE.
- `req_ready` and `uart_tx_en` are zero in every state except SEND.
- A forced release at `MAX_BURST` without `last` is not an error. The requester's remaining bytes go out on its next grant.
- The burst counter is $clog2(MAX_BURST+1) bits wide. The stall counter is $clog2(STALL_CYCLES) bits wide. Neither counter wraps.
- A `req_valid` change on a non-granted requester has no effect until the next IDLE evaluation.
- If `uart_tx_done` arrives while in SEND or GAP, it is ignored.

## Timing
- Reset values: `req_ready`=0, `uart_tx_en`=0, `uart_tx_data`=0, `grant_active`=0, `grant_id`=0, `abort_pulse`=0. `rr_ptr`=0 and state is IDLE.
- Reset asserted mid-frame returns the block to IDLE immediately. The UART shares the reset, so no partial-frame recovery is required.
- Request to transmit: `req_valid` sampled in IDLE at cycle 0 gives SEND at cycle 1. `uart_tx_en` is asserted in cycle 1 if valid is still high. Latency is 1 clock.
- Byte to byte: the `uart_tx_done` cycle goes to SEND the next cycle. The next `uart_tx_en` follows exactly 1 clock after `uart_tx_done`.
- End of grant to next arbitration: `gap_cycles`+1 clocks.
- `abort_pulse` is registered, high for exactly one clock on the SEND-to-GAP/IDLE transition.

## Structure
- Package `uart_sched_pkg` holds:
  - the state enum typedef (`sched_state_t`: IDLE, SEND, WAIT, GAP);
  - the default parameter localparams.
- Sub-module `rr_arbiter`:
  - parameterised by `NUM_REQ`;
  - inputs: request vector and `rr_ptr`;
  - outputs: combinational grant index and an any-request flag.
- Top instantiates `rr_arbiter` and `UART_TX`-facing logic only. The `UART_wrapper` is instantiated by the parent.

## Test plan
- Reset, then requester 2 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), `gap_cycles`=4 → three `uart_tx_en` pulses, each 1 clock after the previous `uart_tx_done`. `grant_id`=2, then idle for 4 clocks.
- Requesters 0 and 1 both hold 2-byte messages → order is 0,0,1,1. Then requester 0 again with `rr_ptr`=2 and only requester 0 valid → grant goes to 0.
- Requester 3 streams 20 bytes with no `last`, `MAX_BURST`=16, requester 1 also valid → 16 bytes from 3, then requester 1's message, then the remaining 4 bytes from 3.
- Grantee drops `req_valid` after byte 1 for `STALL_CYCLES` clocks → `abort_pulse` high for 1 clock, `grant_active`=0, and the next requester is granted.
- `uart_tx_busy` forced high while in SEND → no `uart_tx_en` and no `req_ready` until busy falls.
- Async `rst` asserted in WAIT mid-frame → all outputs reach their reset values without a clock edge. After release, `rr_ptr`=0 and requester 0 wins the first contention.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and default parameters for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAP
  } sched_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_GAP_BITS     = 8;
  localparam int DEF_STALL_CYCLES = 1024;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_req
);

  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to rr_ptr is kept.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        grant_idx = idx;
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Message-granular round-robin sharing of one UART transmitter between
// NUM_REQ byte-stream requesters, with burst limit, stall abort and idle gap.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int GAP_BITS     = DEF_GAP_BITS,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GAP_BITS-1:0]           gap_cycles,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         uart_tx_data,
  output logic                          uart_tx_en,
  input  logic                          uart_tx_busy,
  input  logic                          uart_tx_done,
  output logic                          grant_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          abort_pulse
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int SW  = $clog2(STALL_CYCLES);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES - 1);

  sched_state_t            state;
  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          arb_idx;
  logic                    any_req;
  logic [BW-1:0]           burst_cnt;
  logic [SW-1:0]           stall_cnt;
  logic                    last_q;
  logic [GAP_BITS-1:0]     gap_cnt;
  logic                    fire;
  logic                    end_grant;
  logic [IDW-1:0]          next_ptr;
  logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  // Byte handoff is combinational so a ready requester goes out in its first SEND cycle.
  always_comb begin
    fire         = (state == SEND) && req_valid[grant_id] && !uart_tx_busy;
    uart_tx_en   = fire;
    req_ready    = fire ? (NUM_REQ'(1) << grant_id) : '0;
    uart_tx_data = fire ? req_bytes[grant_id] : '0;
    end_grant    = ((state == SEND) && !fire && (stall_cnt == STALL_MAX)) ||
                   ((state == WAIT) && uart_tx_done && (last_q || (burst_cnt == BURST_MAX)));
    next_ptr     = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant_id     <= '0;
      grant_active <= 1'b0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      stall_cnt    <= '0;
      last_q       <= 1'b0;
      gap_cnt      <= '0;
      abort_pulse  <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id     <= arb_idx;
            grant_active <= 1'b1;
            burst_cnt    <= '0;
            stall_cnt    <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            last_q    <= req_last[grant_id];
            burst_cnt <= burst_cnt + BW'(1);
            state     <= WAIT;
          end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        WAIT: begin
          if (uart_tx_done && !end_grant) begin
            stall_cnt <= '0;
            state     <= SEND;
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_BITS'(1)) state <= IDLE;
          else gap_cnt <= gap_cnt - GAP_BITS'(1);
        end
        default: state <= IDLE;
      endcase

      // Grant release is shared by the stall abort and the normal message end.
      if (end_grant) begin
        grant_active <= 1'b0;
        rr_ptr       <= next_ptr;
        gap_cnt      <= gap_cycles;
        abort_pulse  <= (state == SEND);
        state        <= (gap_cycles != '0) ? GAP : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler with a grant/timestamp reference model and directed scenarios.
module tb_uart_tx_scheduler;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 16;
  localparam int GB    = 8;
  localparam int STALL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [GB-1:0]   gap_cycles;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   uart_tx_data;
  logic            uart_tx_en;
  logic            uart_tx_busy;
  logic            uart_tx_done;
  logic            grant_active;
  logic [1:0]      grant_id;
  logic            abort_pulse;

  uart_tx_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .GAP_BITS(GB), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .rst(rst), .gap_cycles(gap_cycles),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en),
    .uart_tx_busy(uart_tx_busy), .uart_tx_done(uart_tx_done),
    .grant_active(grant_active), .grant_id(grant_id), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Requester byte queues: bit 8 is the last marker.
  logic [8:0] mem [N][512];
  int         head [N];
  int         tail [N];
  logic [N-1:0] hold;

  for (genvar i = 0; i < N; i++) begin : g_req
    assign req_valid[i]         = (tail[i] != head[i]) && !hold[i];
    assign req_data[i*DW +: DW] = mem[i][head[i] & 511][7:0];
    assign req_last[i]          = mem[i][head[i] & 511][8];
  end

  // Transmitter stand-in: busy for a frame, then a one-cycle done.
  logic force_busy = 1'b0;
  logic u_busy = 1'b0;
  logic done_r = 1'b0;
  int   u_cnt = 0;
  bit   rand_frame = 1'b0;
  bit   spur = 1'b0;
  logic en_s;
  logic [N-1:0] rdy_s;
  assign uart_tx_busy = u_busy | force_busy;
  assign uart_tx_done = done_r;

  always begin
    @(negedge clk);
    en_s  = uart_tx_en;
    rdy_s = req_ready;
    @(posedge clk);
    #1;
    if (!rst) begin
      u_busy = 1'b0; u_cnt = 0; done_r = 1'b0;
    end else begin
      for (int r = 0; r < N; r++) if (rdy_s[r]) head[r]++;
      done_r = 1'b0;
      if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) begin u_busy = 1'b0; done_r = 1'b1; end
      end
      if (en_s) begin
        u_busy = 1'b1;
        u_cnt  = rand_frame ? int'($urandom_range(1, 6)) : 4;
      end
      if (spur && u_cnt == 0 && !done_r && $urandom_range(0, 7) == 0) done_r = 1'b1;
    end
  end

  // Transmission log for directed literal checks.
  int log_id  [8192];
  int log_b   [8192];
  int log_cyc [8192];
  int nlog = 0;
  int abort_cyc [256];
  int nabort = 0;

  // Reference model: grant ownership, byte in flight, and the cycle arbitration reopens.
  bit m_granted, m_inflight, m_last;
  int m_gid, m_sent, m_stall, m_rr, m_arb_cycle;
  bit e_active, e_abort;
  int e_gid;

  task automatic m_release();
    m_granted   = 1'b0;
    e_active    = 1'b0;
    m_rr        = (m_gid + 1) % N;
    m_arb_cycle = cyc + 1 + int'(gap_cycles);
  endtask

  always @(negedge clk) begin
    bit fire;
    if (!rst) begin
      m_granted = 0; m_inflight = 0; m_last = 0; m_gid = 0; m_sent = 0; m_stall = 0;
      m_rr = 0; m_arb_cycle = 0; e_active = 0; e_abort = 0; e_gid = 0;
    end else begin
      fire = m_granted && !m_inflight && req_valid[m_gid] && !uart_tx_busy;
      chk("tx_en", 32'(uart_tx_en), 32'(fire));
      chk("req_ready", 32'(req_ready), fire ? (32'd1 << m_gid) : 32'd0);
      if (fire) chk("tx_data", 32'(uart_tx_data), 32'(req_data[m_gid*DW +: DW]));
      chk("grant_active", 32'(grant_active), 32'(e_active));
      chk("grant_id", 32'(grant_id), 32'(e_gid));
      chk("abort_pulse", 32'(abort_pulse), 32'(e_abort));
      if (uart_tx_en && nlog < 8192) begin
        log_id[nlog] = -1;
        for (int r = 0; r < N; r++) if (req_ready[r]) log_id[nlog] = r;
        log_b[nlog]   = int'(uart_tx_data);
        log_cyc[nlog] = cyc;
        nlog++;
      end
      if (abort_pulse && nabort < 256) begin abort_cyc[nabort] = cyc; nabort++; end

      e_abort = 1'b0;
      if (!m_granted) begin
        if (cyc >= m_arb_cycle && |req_valid) begin
          for (int k = N - 1; k >= 0; k--)
            if (req_valid[(m_rr + k) % N]) m_gid = (m_rr + k) % N;
          m_granted = 1; m_inflight = 0; m_sent = 0; m_stall = 0;
          e_active = 1; e_gid = m_gid;
        end
      end else if (!m_inflight) begin
        if (fire) begin
          m_sent++; m_last = req_last[m_gid]; m_inflight = 1; m_stall = 0;
        end else if (m_stall == STALL - 1) begin
          e_abort = 1'b1;
          m_release();
        end else begin
          m_stall++;
        end
      end else if (uart_tx_done) begin
        m_inflight = 0;
        if (m_last || m_sent == MB) m_release();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic last);
    mem[r][tail[r] & 511] = {last, b};
    tail[r]++;
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < N; r++) if (head[r] != tail[r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_quiet(input int budget);
    int k = 0;
    while (k < budget && !(all_empty() && !grant_active && u_cnt == 0 && !uart_tx_busy)) begin
      tick(1); k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL quiet_timeout: still busy after %0d cycles", budget);
    end
    tick(10);
  endtask

  initial begin
    int base, p, rel, na, b;
    logic [7:0] exp_b;
    int exp_id;
    rst = 1'b0;
    gap_cycles = '0;
    hold = '0;
    for (int r = 0; r < N; r++) begin
      head[r] = 0; tail[r] = 0;
      for (int j = 0; j < 512; j++) mem[r][j] = '0;
    end
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_en", 32'(uart_tx_en), 0);
    chk("rst_data", 32'(uart_tx_data), 0);
    chk("rst_active", 32'(grant_active), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_abort", 32'(abort_pulse), 0);
    tick(3);
    rst = 1'b1;
    tick(2);

    // Three-byte message from requester 2 with a 4-clock gap, then requester 1.
    gap_cycles = 8'd4;
    base = nlog; p = cyc;
    push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
    tick(2);
    push(1, 8'h55, 1);
    wait_quiet(500);
    chk("t1_count", 32'(nlog - base), 4);
    for (int i = 0; i < 3; i++) begin
      chk("t1_id", 32'(log_id[base+i]), 2);
      chk("t1_byte", 32'(log_b[base+i]), 32'(8'hA1 + i));
    end
    chk("t1_first_latency", 32'(log_cyc[base] - p), 1);
    chk("t1_byte_spacing1", 32'(log_cyc[base+1] - log_cyc[base]), 6);
    chk("t1_byte_spacing2", 32'(log_cyc[base+2] - log_cyc[base+1]), 6);
    chk("t1_gap_spacing", 32'(log_cyc[base+3] - log_cyc[base+2]), 11);
    chk("t1_next_id", 32'(log_id[base+3]), 1);

    // Contention between requesters 0 and 1, then requester 0 alone.
    gap_cycles = 8'd0;
    base = nlog;
    push(0, 8'hB0, 0); push(0, 8'hB1, 1);
    push(1, 8'hC0, 0); push(1, 8'hC1, 1);
    wait_quiet(500);
    push(0, 8'hD0, 1);
    wait_quiet(500);
    chk("t2_count", 32'(nlog - base), 5);
    for (int i = 0; i < 5; i++) begin
      exp_id = (i == 2 || i == 3) ? 1 : 0;
      exp_b  = (i == 0) ? 8'hB0 : (i == 1) ? 8'hB1 : (i == 2) ? 8'hC0 : (i == 3) ? 8'hC1 : 8'hD0;
      chk("t2_id", 32'(log_id[base+i]), 32'(exp_id));
      chk("t2_byte", 32'(log_b[base+i]), 32'(exp_b));
    end

    // Stall abort: requester 0 runs dry after one byte, requester 2 waits.
    base = nlog; na = nabort;
    push(0, 8'hE0, 0);
    tick(2);
    push(2, 8'hF0, 1);
    wait_quiet(500);
    chk("t3_abort_count", 32'(nabort - na), 1);
    chk("t3_abort_time", 32'(abort_cyc[na] - log_cyc[base]), 38);
    chk("t3_next_id", 32'(log_id[base+1]), 2);
    chk("t3_next_time", 32'(log_cyc[base+1] - abort_cyc[na]), 1);

    // Burst limit: 20 bytes from requester 3 interleaved with requester 1.
    base = nlog;
    for (int i = 0; i < 20; i++) push(3, 8'(8'h30 + i), (i == 19));
    push(1, 8'h90, 0); push(1, 8'h91, 1);
    wait_quiet(1000);
    chk("t4_count", 32'(nlog - base), 22);
    for (int i = 0; i < 22; i++) begin
      if (i < 16) begin exp_id = 3; exp_b = 8'(8'h30 + i); end
      else if (i < 18) begin exp_id = 1; exp_b = 8'(8'h90 + i - 16); end
      else begin exp_id = 3; exp_b = 8'(8'h30 + i - 2); end
      chk("t4_id", 32'(log_id[base+i]), 32'(exp_id));
      chk("t4_byte", 32'(log_b[base+i]), 32'(exp_b));
    end

    // Transmitter busy while granted holds off the byte.
    base = nlog;
    force_busy = 1'b1;
    push(2, 8'h71, 0); push(2, 8'h72, 1);
    tick(12);
    chk("t5_held", 32'(nlog - base), 0);
    force_busy = 1'b0;
    rel = cyc;
    wait_quiet(500);
    chk("t5_count", 32'(nlog - base), 2);
    chk("t5_release_time", 32'(log_cyc[base] - rel), 0);

    // Asynchronous reset while a frame is in flight.
    base = nlog;
    for (int i = 0; i < 5; i++) push(1, 8'(8'h60 + i), (i == 4));
    b = 0;
    while (nlog == base && b < 200) begin tick(1); b++; end
    chk("t6_started", 32'(nlog > base), 1);
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_ready", 32'(req_ready), 0);
    chk("t6_en", 32'(uart_tx_en), 0);
    chk("t6_data", 32'(uart_tx_data), 0);
    chk("t6_active", 32'(grant_active), 0);
    chk("t6_gid", 32'(grant_id), 0);
    chk("t6_abort", 32'(abort_pulse), 0);
    tick(1);
    push(0, 8'h11, 1);
    push(3, 8'h33, 1);
    tick(2);
    base = nlog;
    rst = 1'b1;
    wait_quiet(1000);
    chk("t6_first_id", 32'(log_id[base]), 0);
    chk("t6_first_byte", 32'(log_b[base]), 32'(8'h11));

    // Randomised traffic with holds, busy stretches, gap changes and stray done pulses.
    rand_frame = 1'b1;
    spur = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        int r, len;
        r = int'($urandom_range(0, N - 1));
        len = int'($urandom_range(1, 20));
        if (tail[r] - head[r] < 100)
          for (int j = 0; j < len; j++) push(r, 8'($urandom), (j == len - 1));
      end
      if ($urandom_range(0, 49) == 0) gap_cycles = 8'($urandom_range(0, 5));
      if (force_busy) begin
        if ($urandom_range(0, 3) == 0) force_busy = 1'b0;
      end else if ($urandom_range(0, 39) == 0) force_busy = 1'b1;
      for (int r = 0; r < N; r++) begin
        if (hold[r]) begin
          if ($urandom_range(0, 19) == 0) hold[r] = 1'b0;
        end else if ($urandom_range(0, 199) == 0) hold[r] = 1'b1;
      end
      tick(1);
    end
    hold = '0;
    force_busy = 1'b0;
    wait_quiet(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
